// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-time table, timer width, receive FSM encoding.
package uart_pkg;

  localparam int K_W    = 19;
  localparam int DATA_W = 8;
  localparam int SR_W   = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clocks per bit for each BAUD code; the unused codes fall back to the fastest rate.
  function automatic logic [K_W-1:0] bit_time(input logic [3:0] baud);
    case (baud)
      4'd0:    bit_time = 19'd333333;
      4'd1:    bit_time = 19'd83333;
      4'd2:    bit_time = 19'd41667;
      4'd3:    bit_time = 19'd20833;
      4'd4:    bit_time = 19'd10417;
      4'd5:    bit_time = 19'd5208;
      4'd6:    bit_time = 19'd2604;
      4'd7:    bit_time = 19'd1736;
      4'd8:    bit_time = 19'd868;
      4'd9:    bit_time = 19'd434;
      4'd10:   bit_time = 19'd217;
      4'd11:   bit_time = 19'd109;
      default: bit_time = 19'd109;
    endcase
  endfunction

endpackage

// File: rtl/receive_eng_if.sv
// Consumer-side bus of the receive engine: frame status/data out, read strobe in.
interface receive_eng_if;
  import uart_pkg::*;

  logic              read_0;
  logic              rxrdy;
  logic [DATA_W-1:0] rx_data;
  logic              perr;
  logic              ferr;
  logic              ovf;

  modport master (input read_0, output rxrdy, rx_data, perr, ferr, ovf);
  modport slave  (output read_0, input rxrdy, rx_data, perr, ferr, ovf);

endinterface

// File: rtl/uart_bit_timer.sv
// Down-counting bit timer: load a period, pulse done for one cycle when it expires.
// A load in the same cycle as done restarts the count, so periods chain back to back.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [K_W-1:0] load_val,
  output logic           done
);

  logic [K_W-1:0] cnt;
  logic           active;

  assign done = active && (cnt == K_W'(1));

  // Count down from the loaded period; go inactive once the period has elapsed.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= load_val;
      active <= 1'b1;
    end else if (active) begin
      cnt <= cnt - K_W'(1);
      if (cnt == K_W'(1)) active <= 1'b0;
    end
  end

endmodule

// File: rtl/receive_eng.sv
// UART receive engine: synchronizes RX, frames start/data/parity/stop bits at the
// latched bit rate, and presents the result with ready, parity, framing and overrun flags.
module receive_eng
  import uart_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   baud,
  input  logic         eight,
  input  logic         parity_en,
  input  logic         odd_n_even,
  input  logic         rx,
  receive_eng_if.master bus
);

  // Line synchronizer and its validity tracking
  logic rx_p0, rx_p1;
  logic vld_p0, vld_p1;
  logic armed;

  // Frame control
  rx_state_t      state, state_nxt;
  logic           tmr_load, tmr_done;
  logic [K_W-1:0] tmr_val;
  logic           cfg_latch, shift_en, deliver;

  // Latched frame configuration and datapath
  logic [3:0]        baud_l;
  logic              eight_l, par_l, odd_l;
  logic [3:0]        bit_cnt;
  logic [3:0]        n_bits;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   aligned;
  logic [K_W-1:0]    k_frame;
  logic [DATA_W-1:0] frame_data;
  logic              frame_pbit;

  // Held results seen by the consumer
  logic              held_rdy, held_perr, held_ferr, held_ovf;
  logic [DATA_W-1:0] held_data;

  // True when the received parity bit disagrees with the configured parity of the data.
  function automatic logic parity_err(input logic [DATA_W-1:0] d, input logic pbit,
                                      input logic odd, input logic en);
    parity_err = en & (pbit ^ (^d) ^ odd);
  endfunction

  assign k_frame = bit_time(baud_l);
  assign n_bits  = (eight_l ? 4'd8 : 4'd7) + {3'b000, par_l};

  // Samples enter at the top of the shift register; right-align them by frame length.
  assign aligned    = sr >> (4'd9 - n_bits);
  assign frame_data = eight_l ? aligned[7:0] : {1'b0, aligned[6:0]};
  assign frame_pbit = eight_l ? aligned[8] : aligned[7];

  uart_bit_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // --- stage p0/p1: two-flop synchronizer; armed once a real high level is seen ---
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0  <= 1'b1;
      rx_p1  <= 1'b1;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      armed  <= 1'b0;
    end else begin
      rx_p0  <= rx;
      rx_p1  <= rx_p0;
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
      armed  <= armed | (vld_p1 & rx_p1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and per-cycle strobes for timer, config latch, shift and delivery.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = k_frame;
    cfg_latch = 1'b0;
    shift_en  = 1'b0;
    deliver   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !rx_p1) begin
          cfg_latch = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = bit_time(baud) >> 1;
          state_nxt = START;
        end
      end
      START: begin
        if (tmr_done) begin
          if (rx_p1) begin
            state_nxt = IDLE;
          end else begin
            tmr_load  = 1'b1;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (tmr_done) begin
          shift_en = 1'b1;
          tmr_load = 1'b1;
          if (bit_cnt == n_bits - 4'd1) state_nxt = STOP;
        end
      end
      STOP: begin
        if (tmr_done) begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame configuration captured at start detection, then bit counting and sample shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_l  <= '0;
      eight_l <= 1'b0;
      par_l   <= 1'b0;
      odd_l   <= 1'b0;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      if (cfg_latch) begin
        baud_l  <= baud;
        eight_l <= eight;
        par_l   <= parity_en;
        odd_l   <= odd_n_even;
      end
      if (state != DATA)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 4'd1;
      if (shift_en) sr <= {rx_p1, sr[SR_W-1:1]};
    end
  end

  // --- stage p2: deliver completed frame and manage ready/overrun against reads ---
  always_ff @(posedge clk) begin
    if (reset) begin
      held_rdy  <= 1'b0;
      held_data <= '0;
      held_perr <= 1'b0;
      held_ferr <= 1'b0;
      held_ovf  <= 1'b0;
    end else if (deliver) begin
      held_rdy  <= 1'b1;
      held_data <= frame_data;
      held_perr <= parity_err(frame_data, frame_pbit, odd_l, par_l);
      held_ferr <= ~rx_p1;
      held_ovf  <= held_rdy & ~bus.read_0;
    end else if (bus.read_0 && held_rdy) begin
      held_rdy <= 1'b0;
      held_ovf <= 1'b0;
    end
  end

  assign bus.rxrdy   = held_rdy;
  assign bus.rx_data = held_data;
  assign bus.perr    = held_perr;
  assign bus.ferr    = held_ferr;
  assign bus.ovf     = held_ovf;

endmodule

// File: tb/tb_receive_eng.sv
// Bench for receive_eng: drives serial frames bit by bit and compares the consumer
// outputs against a frame-level model of the receiver's rules.
module tb_receive_eng;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] baud;
  logic       eight, parity_en, odd_n_even, rx;

  receive_eng_if bus ();

  receive_eng dut (
    .clk        (clk),
    .reset      (reset),
    .baud       (baud),
    .eight      (eight),
    .parity_en  (parity_en),
    .odd_n_even (odd_n_even),
    .rx         (rx),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int k_tab [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                     868, 434, 217, 109, 109, 109, 109, 109};

  // Reference model state
  logic       m_rdy, m_perr, m_ferr, m_ovf;
  logic [7:0] m_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int rise_cyc  = -1;
  logic rdy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rxrdy && !rdy_prev) rise_cyc = cyc;
    rdy_prev = bus.rxrdy;
  end

  function automatic logic [11:0] got();
    got = {bus.rxrdy, bus.rx_data, bus.perr, bus.ferr, bus.ovf};
  endfunction

  function automatic logic [11:0] want();
    want = {m_rdy, m_data, m_perr, m_ferr, m_ovf};
  endfunction

  // Parity bit a correct transmitter would send for these data bits.
  function automatic logic correct_pbit(input logic [7:0] d, input logic odd);
    correct_pbit = (($countones(d) % 2) == 1) ? !odd : odd;
  endfunction

  function automatic void model_reset();
    m_rdy = 0; m_data = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] d, input logic e, input logic p,
                                      input logic odd, input logic pbit, input logic stop);
    logic [7:0] d_rx;
    d_rx = e ? d : {1'b0, d[6:0]};
    if (m_rdy) m_ovf = 1;
    m_rdy  = 1;
    m_data = d_rx;
    m_perr = p && (pbit != correct_pbit(d_rx, odd));
    m_ferr = !stop;
  endfunction

  function automatic void model_read();
    if (m_rdy) begin
      m_rdy = 0;
      m_ovf = 0;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read();
    bus.read_0 = 1'b1;
    tick(1);
    bus.read_0 = 1'b0;
    tick(1);
    model_read();
  endtask

  // Send one frame starting at a falling clock edge; optionally garble config mid-frame.
  task automatic send_frame(input logic [7:0] d, input logic [3:0] b, input logic e,
                            input logic p, input logic odd, input logic pbit,
                            input logic stop, input int idle, input bit scramble);
    int k;
    k = k_tab[b];
    baud = b; eight = e; parity_en = p; odd_n_even = odd;
    start_cyc = cyc;
    rx = 1'b0;
    tick(k);
    if (scramble) begin
      baud = 4'($urandom); eight = 1'($urandom);
      parity_en = 1'($urandom); odd_n_even = 1'($urandom);
    end
    for (int i = 0; i < (e ? 8 : 7); i++) begin
      rx = d[i];
      tick(k);
    end
    if (p) begin
      rx = pbit;
      tick(k);
    end
    baud = b; eight = e; parity_en = p; odd_n_even = odd;
    rx = stop;
    tick(k);
    rx = 1'b1;
    tick(stop ? idle : idle + 2 * k);
    model_frame(d, e, p, odd, pbit, stop);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; bus.read_0 = 1'b0;
    baud = 4'd11; eight = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    tick(4);
    reset = 1'b0;
    model_reset();
    tick(4);
    n_checks++;
    if (got() !== want()) $display("FAIL reset_state: got %03h want %03h", got(), want());
    else n_pass++;
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
    n_checks++;
    if (got() !== want()) $display("FAIL basic_frame: got %03h want %03h", got(), want());
    else n_pass++;
    n_checks++;
    if (rise_cyc <= start_cyc || (rise_cyc - start_cyc) > 11 * 109 + 4)
      $display("FAIL basic_latency: got %0d clocks want 1..%0d", rise_cyc - start_cyc, 11 * 109 + 4);
    else n_pass++;
    do_read();
    n_checks++;
    if (got() !== want()) $display("FAIL basic_read: got %03h want %03h", got(), want());
    else n_pass++;
    // A read with nothing pending leaves everything as it is.
    do_read();
    n_checks++;
    if (got() !== want()) $display("FAIL idle_read: got %03h want %03h", got(), want());
    else n_pass++;
  endtask

  task automatic test_parity();
    logic pb;
    for (int i = 0; i < 2; i++) begin
      pb = (i == 0) ? 1'b1 : 1'b0;
      send_frame(8'h55, 4'd11, 1'b0, 1'b1, 1'b1, pb, 1'b1, 4, 1'b0);
      n_checks++;
      if (got() !== want()) $display("FAIL parity_pbit%0d: got %03h want %03h", pb, got(), want());
      else n_pass++;
      do_read();
    end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    n_checks++;
    if (got() !== want()) $display("FAIL framing_err: got %03h want %03h", got(), want());
    else n_pass++;
    do_read();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'h22, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
    n_checks++;
    if (got() !== want()) $display("FAIL overrun_set: got %03h want %03h", got(), want());
    else n_pass++;
    do_read();
    n_checks++;
    if (got() !== want()) $display("FAIL overrun_clear: got %03h want %03h", got(), want());
    else n_pass++;
  endtask

  task automatic test_false_start();
    baud = 4'd11;
    rx = 1'b0;
    tick(30);
    rx = 1'b1;
    tick(300);
    n_checks++;
    if (got() !== want()) $display("FAIL false_start: got %03h want %03h", got(), want());
    else n_pass++;
    send_frame(8'h5A, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
    n_checks++;
    if (got() !== want()) $display("FAIL after_false_start: got %03h want %03h", got(), want());
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'hF3;
    // Leave the previous frame unread so the reset has something to clear.
    baud = 4'd11; eight = 1'b1; parity_en = 1'b0;
    rx = 1'b0;
    tick(109);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      tick(109);
    end
    rx = d[4];
    tick(50);
    reset = 1'b1;
    tick(1);
    model_reset();
    n_checks++;
    if (got() !== want()) $display("FAIL reset_midframe: got %03h want %03h", got(), want());
    else n_pass++;
    reset = 1'b0;
    tick(59);
    for (int i = 5; i < 8; i++) begin
      rx = d[i];
      tick(109);
    end
    rx = 1'b1;
    tick(400);
    n_checks++;
    if (got() !== want()) $display("FAIL discard_partial: got %03h want %03h", got(), want());
    else n_pass++;
  endtask

  task automatic test_held_low_reset();
    rx = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    model_reset();
    tick(3 * 109);
    n_checks++;
    if (got() !== want()) $display("FAIL held_low: got %03h want %03h", got(), want());
    else n_pass++;
    rx = 1'b1;
    tick(10);
    send_frame(8'hC3, 4'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b0);
    n_checks++;
    if (got() !== want()) $display("FAIL after_held_low: got %03h want %03h", got(), want());
    else n_pass++;
    do_read();
  endtask

  task automatic test_random();
    logic [7:0] d, d_rx;
    logic [3:0] b;
    logic e, p, odd, wrong, stop, pb;
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      b = 4'($urandom_range(10, 15));
      e = 1'($urandom); p = 1'($urandom); odd = 1'($urandom);
      wrong = ($urandom % 4) == 0;
      stop = ($urandom % 5) != 0;
      d_rx = e ? d : {1'b0, d[6:0]};
      pb = correct_pbit(d_rx, odd) ^ wrong;
      send_frame(d, b, e, p, odd, pb, stop, 4, 1'b1);
      n_checks++;
      if (got() !== want()) $display("FAIL random_%0d: got %03h want %03h", n, got(), want());
      else n_pass++;
      if ($urandom % 2) do_read();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_back_to_back();
    test_false_start();
    test_reset_midframe();
    test_held_low_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
